// File: rtl/pipe_fetchq.sv
// Purpose: 4-entry instruction fetch queue decoupling IF {pc4, ins} from ID; flush empties it.
// Latency: 1 cycle from an accepted push to out_valid (no bypass); the head is shown straight from storage.
// Backpressure: wpcir=0 while full (comes from the registered count only); id_ready pops the head when out_valid.
//
// Ports:
//   clock, resetn        : clock and synchronous active-low reset
//   pc4, ins, in_valid   : fetched PC+4 and instruction word from IF, qualified by in_valid
//   id_ready             : ID consumes the head entry this cycle
//   flush                : taken branch/jump; discards queued and incoming entries
//   dpc4, inst           : head entry (zero when empty; inst=0 is a NOP into ID)
//   out_valid            : head entry valid (count != 0)
//   wpcir                : IF may advance PC/IR (count != DEPTH)
//   count                : number of occupied entries, 0..DEPTH
module pipe_fetchq #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] pc4,
  input  logic [31:0] ins,
  input  logic        in_valid,
  input  logic        id_ready,
  input  logic        flush,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        out_valid,
  output logic        wpcir,
  output logic [2:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [2:0]       FULL_CNT = 3'(DEPTH);
  localparam logic [2:0]       CNT_ONE  = 3'd1;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] ins;
  } entry_t;

  // Storage is deliberately not reset: an entry is only visible once count covers it.
  entry_t           mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q,  count_d;

  logic             push;
  logic             pop;
  entry_t           head;

  // Status comes only from the registered count, so IF never sees a
  // combinational path from in_valid, id_ready or flush.
  assign out_valid = (count_q != 3'd0);
  assign wpcir     = (count_q != FULL_CNT);
  assign count     = count_q;

  // Flush cancels both directions in the same cycle.
  assign push = in_valid & wpcir & ~flush;
  assign pop  = out_valid & id_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Collapse onto the current write pointer; the stale entries become unreachable.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
      count_d  = 3'd0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Writes are gated by push, which already excludes flush; reset does not
  // need to block them because count is cleared alongside.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc4: pc4, ins: ins};
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign dpc4 = out_valid ? head.pc4 : 32'h0;
  assign inst = out_valid ? head.ins : 32'h0;

endmodule

// File: tb/tb_pipe_fetchq.sv
module tb_pipe_fetchq;

  logic        clock;
  logic        resetn;
  logic [31:0] pc4;
  logic [31:0] ins;
  logic        in_valid;
  logic        id_ready;
  logic        flush;
  logic [31:0] dpc4;
  logic [31:0] inst;
  logic        out_valid;
  logic        wpcir;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  // Expected {pc4, ins} of every accepted push, in acceptance order.
  logic [63:0] exp_q [$];

  pipe_fetchq #(.DEPTH(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .pc4       (pc4),
    .ins       (ins),
    .in_valid  (in_valid),
    .id_ready  (id_ready),
    .flush     (flush),
    .dpc4      (dpc4),
    .inst      (inst),
    .out_valid (out_valid),
    .wpcir     (wpcir),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: on the falling edge, if the DUT will pop at the next rising
  // edge, the head it presents must be the oldest expected entry.
  initial begin
    forever begin
      @(negedge clock);
      if (resetn === 1'b1 && out_valid === 1'b1 && id_ready === 1'b1 && flush === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_unexpected_pop: got dpc4=0x%08h inst=0x%08h expected no entry", dpc4, inst);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("mon_dpc4", dpc4, e[63:32]);
          chk("mon_inst", inst, e[31:0]);
        end
      end
    end
  end

  // One clock of stimulus; acc says whether this cycle's push is expected to be accepted.
  task automatic step(input logic v, input logic [31:0] p, input logic [31:0] i,
                      input logic r, input logic f, input logic acc);
    in_valid = v;
    pc4      = p;
    ins      = i;
    id_ready = r;
    flush    = f;
    @(posedge clock);
    #1;
    if (acc) exp_q.push_back({p, i});
    if (f) exp_q.delete();
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_wpcir"}, 32'(wpcir), 32'd1);
    chk({tag, "_dpc4"}, dpc4, 32'h0);
    chk({tag, "_inst"}, inst, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    pc4      = 32'h0;
    ins      = 32'h0;
    id_ready = 1'b0;
    flush    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_empty("reset");
    resetn = 1'b1;

    // Single push becomes visible one cycle later.
    step(1'b1, 32'h4, 32'h20010005, 1'b0, 1'b0, 1'b1);
    chk("first_out_valid", 32'(out_valid), 32'd1);
    chk("first_dpc4", dpc4, 32'h4);
    chk("first_inst", inst, 32'h20010005);
    chk("first_count", 32'(count), 32'd1);
    idle();
    drain(1);
    check_empty("first_drained");

    // Fill to full, fifth push ignored, drain in order.
    for (int k = 1; k <= 4; k++)
      step(1'b1, 32'(4 * k), 32'hA0000000 | 32'(4 * k), 1'b0, 1'b0, 1'b1);
    chk("full_count", 32'(count), 32'd4);
    chk("full_wpcir", 32'(wpcir), 32'd0);
    step(1'b1, 32'h14, 32'hA0000014, 1'b0, 1'b0, 1'b0);
    chk("full_ignored_count", 32'(count), 32'd4);
    for (int k = 3; k >= 0; k--) begin
      drain(1);
      chk("full_drain_count", 32'(count), 32'(k));
    end
    check_empty("full_drained");

    // Pop at full: no same-cycle refill, refill on the following cycle.
    for (int k = 1; k <= 4; k++)
      step(1'b1, 32'h40 + 32'(4 * k), 32'hB0000000 + 32'(k), 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h100, 32'hC0000100, 1'b1, 1'b0, 1'b0);
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_wpcir", 32'(wpcir), 32'd1);
    step(1'b1, 32'h104, 32'hC0000104, 1'b1, 1'b0, 1'b1);
    chk("fullpop_refill_count", 32'(count), 32'd3);
    drain(3);
    check_empty("fullpop_drained");

    // Streaming: push and pop every cycle, pointers wrap repeatedly.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 32'h200 + 32'(4 * k), 32'hD0000000 + 32'(k), 1'b1, 1'b0, 1'b1);
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_dpc4", dpc4, 32'h200 + 32'(4 * k));
    end
    drain(1);
    check_empty("stream_drained");

    // Flush at count=3 with push and pop in the same cycle.
    for (int k = 0; k < 3; k++)
      step(1'b1, 32'h280 + 32'(4 * k), 32'hE0000000 + 32'(k), 1'b0, 1'b0, 1'b1);
    chk("preflush_count", 32'(count), 32'd3);
    step(1'b1, 32'h2FC, 32'hE00000FF, 1'b1, 1'b1, 1'b0);
    check_empty("flush");
    step(1'b1, 32'h300, 32'h00A00093, 1'b0, 1'b0, 1'b1);
    chk("postflush_count", 32'(count), 32'd1);
    chk("postflush_dpc4", dpc4, 32'h300);
    chk("postflush_inst", inst, 32'h00A00093);
    drain(1);
    check_empty("postflush_drained");

    // Reset mid-operation at count=2 with a push attempt.
    step(1'b1, 32'h400, 32'hF0000000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h404, 32'hF0000001, 1'b0, 1'b0, 1'b1);
    chk("prereset_count", 32'(count), 32'd2);
    resetn = 1'b0;
    step(1'b1, 32'h408, 32'hF0000002, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    check_empty("midreset");
    resetn = 1'b1;
    step(1'b1, 32'h500, 32'h12345678, 1'b0, 1'b0, 1'b1);
    chk("postreset_dpc4", dpc4, 32'h500);
    drain(1);
    idle();

    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
